// File: rtl/tank_pkg.sv
// Shared definitions for the tank level model: state and fault encodings,
// default rates/thresholds and the width of the signed net-flow value.
package tank_pkg;

  typedef enum logic [1:0] {
    ST_STEADY   = 2'd0,
    ST_FILLING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_FULL     = 2'd3
  } tank_state_e;

  typedef enum logic [1:0] {
    FLT_NONE        = 2'd0,
    FLT_HIGH_STUCK1 = 2'd1,
    FLT_MID_STUCK0  = 2'd2,
    FLT_LOW_STUCK0  = 2'd3
  } fault_sel_e;

  localparam int unsigned DEF_TICK_DIV  = 50000000;
  localparam int unsigned DEF_LEVEL_MAX = 200;
  localparam int unsigned DEF_FILL_RATE = 4;
  localparam int unsigned DEF_SPR_RATE  = 3;
  localparam int unsigned DEF_DRIP_RATE = 1;
  localparam int unsigned DEF_L_TH      = 40;
  localparam int unsigned DEF_M_TH      = 100;
  localparam int unsigned DEF_H_TH      = 160;

  localparam int NET_W = 10;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick
// lands DIV cycles after reset release.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tank_level_model.sv
// Tank level model: tick-paced saturating level integrator with state FSM,
// sticky overflow, preset-load handshake and faultable thermometer sensors.
module tank_level_model
  import tank_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned LEVEL_MAX = DEF_LEVEL_MAX,
  parameter int unsigned FILL_RATE = DEF_FILL_RATE,
  parameter int unsigned SPR_RATE  = DEF_SPR_RATE,
  parameter int unsigned DRIP_RATE = DEF_DRIP_RATE,
  parameter int unsigned L_TH      = DEF_L_TH,
  parameter int unsigned M_TH      = DEF_M_TH,
  parameter int unsigned H_TH      = DEF_H_TH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valve_in,
  input  logic       valve_spr,
  input  logic       valve_drip,
  input  logic       load_valid,
  input  logic [7:0] load_level,
  output logic       load_ready,
  input  logic [1:0] fault_sel,
  input  logic       ovf_clr,
  output logic       high,
  output logic       middle,
  output logic       low,
  output logic [7:0] level,
  output logic [1:0] state,
  output logic       overflow
);

  localparam logic [7:0] LMAX8 = 8'(LEVEL_MAX);
  localparam logic [7:0] L8    = 8'(L_TH);
  localparam logic [7:0] M8    = 8'(M_TH);
  localparam logic [7:0] H8    = 8'(H_TH);

  localparam logic signed [NET_W-1:0] FILL_S = NET_W'(FILL_RATE);
  localparam logic signed [NET_W-1:0] SPR_S  = NET_W'(SPR_RATE);
  localparam logic signed [NET_W-1:0] DRIP_S = NET_W'(DRIP_RATE);

  function automatic logic [7:0] sat_level(input logic [7:0] cur,
                                           input logic signed [NET_W-1:0] d);
    logic signed [NET_W:0] sum;
    sum = $signed({3'b000, cur}) + $signed({d[NET_W-1], d});
    if (sum < 0)                             return 8'd0;
    else if (sum > $signed({3'b000, LMAX8})) return LMAX8;
    else                                     return sum[7:0];
  endfunction

  function automatic logic [7:0] clamp_load(input logic [7:0] req);
    return (req > LMAX8) ? LMAX8 : req;
  endfunction

  logic tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  logic signed [NET_W-1:0] net;
  logic [7:0]  lvl_tick;
  logic        load_acc;
  logic        ovf_set;

  logic [7:0]  level_q, level_d;
  tank_state_e state_q, state_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  sens_q, sens_d;

  always_comb begin
    net = '0;
    if (valve_in)   net = net + FILL_S;
    if (valve_spr)  net = net - SPR_S;
    if (valve_drip) net = net - DRIP_S;
  end

  // A tick always has priority; a held load simply waits for a tick-free cycle.
  assign lvl_tick   = sat_level(level_q, net);
  assign load_acc   = load_valid & ~tick & rst_n;
  assign load_ready = load_acc;
  assign ovf_set    = tick && (level_q == LMAX8) && (net > 0);

  always_comb begin
    level_d = level_q;
    if (tick)          level_d = lvl_tick;
    else if (load_acc) level_d = clamp_load(load_level);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    sens_d = {(level_q >= H8), (level_q >= M8), (level_q >= L8)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      sens_q  <= '0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      sens_q  <= sens_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STEADY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      if ((net > 0) && (lvl_tick < LMAX8))        state_d = ST_FILLING;
      else if ((lvl_tick == LMAX8) && (net >= 0)) state_d = ST_FULL;
      else if (net < 0)                           state_d = ST_DRAINING;
      else                                        state_d = ST_STEADY;
    end else if (load_acc) begin
      state_d = ST_STEADY;
    end
  end

  always_comb begin
    state = state_q;
  end

  // Faults sit after the sensor register so they never feed back into level.
  always_comb begin
    high   = sens_q[2];
    middle = sens_q[1];
    low    = sens_q[0];
    case (fault_sel_e'(fault_sel))
      FLT_HIGH_STUCK1: high   = 1'b1;
      FLT_MID_STUCK0:  middle = 1'b0;
      FLT_LOW_STUCK0:  low    = 1'b0;
      default: ;
    endcase
  end

  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tank_level_model.sv
// Directed bench for tank_level_model with TICK_DIV=4; scenarios run in order.
module tb_tank_level_model;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valve_in = 1'b0, valve_spr = 1'b0, valve_drip = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_level = 8'd0;
  logic       load_ready;
  logic [1:0] fault_sel = 2'd0;
  logic       ovf_clr = 1'b0;
  logic       high, middle, low;
  logic [7:0] level;
  logic [1:0] state;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  // Independent prescaler model used only to know where tick cycles fall.
  logic [1:0] pc;
  logic       tick_m;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 2'd0;
    else        pc <= (pc == 2'd3) ? 2'd0 : pc + 2'd1;
  end
  assign tick_m = (pc == 2'd3);

  tank_level_model #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valve_in(valve_in), .valve_spr(valve_spr), .valve_drip(valve_drip),
    .load_valid(load_valid), .load_level(load_level), .load_ready(load_ready),
    .fault_sel(fault_sel), .ovf_clr(ovf_clr),
    .high(high), .middle(middle), .low(low),
    .level(level), .state(state), .overflow(overflow)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 8 * n + 8) begin
      if (tick_m) k++;
      step();
      guard++;
    end
    vectors++;
    if (k < n) begin
      miscompares++;
      $display("FAIL wait_ticks saw %0d ticks, needed %0d", k, n);
    end
  endtask

  task automatic to_tick();
    int guard = 0;
    while (!tick_m && guard < 8) begin
      step();
      guard++;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    int g = 0;
    load_level = v;
    load_valid = 1'b1;
    #1;
    while (!load_ready && g < 10) begin
      step();
      g++;
    end
    vectors++;
    if (!load_ready) begin
      miscompares++;
      $display("FAIL load_handshake load_ready=%0b after %0d cycles, required 1", load_ready, g);
    end
    step();
    load_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({level, state, overflow, load_ready, high, middle, low} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs level=%0d state=%0d ovf=%0b rdy=%0b hml=%0b%0b%0b, required all 0",
               level, state, overflow, load_ready, high, middle, low);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    valve_in = 1'b1;
    repeat (3) step();
    vectors++;
    if (level !== 8'd0) begin
      miscompares++;
      $display("FAIL first_tick_early level=%0d, required 0", level);
    end
    step();
    vectors++;
    if (level !== 8'd4) begin
      miscompares++;
      $display("FAIL first_tick level=%0d, required 4", level);
    end
    wait_ticks(9);
    vectors++;
    if (level !== 8'd40 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL fill_10_ticks level=%0d state=%0d, required 40/1", level, state);
    end
    vectors++;
    if (low !== 1'b0) begin
      miscompares++;
      $display("FAIL low_latency low=%0b, required 0 in tick cycle", low);
    end
    valve_in = 1'b0;
    step();
    vectors++;
    if (low !== 1'b1 || middle !== 1'b0) begin
      miscompares++;
      $display("FAIL low_sensor low=%0b middle=%0b, required 1/0", low, middle);
    end
  endtask

  task automatic test_full_overflow();
    do_load(8'd198);
    vectors++;
    if (level !== 8'd198 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL load_198 level=%0d state=%0d, required 198/0", level, state);
    end
    valve_in = 1'b1;
    wait_ticks(1);
    vectors++;
    if (level !== 8'd200 || state !== 2'd3 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_tick1 level=%0d state=%0d ovf=%0b, required 200/3/0", level, state, overflow);
    end
    wait_ticks(1);
    vectors++;
    if (level !== 8'd200 || state !== 2'd3 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_tick2 level=%0d state=%0d ovf=%0b, required 200/3/1", level, state, overflow);
    end
  endtask

  task automatic test_ovf_clr();
    to_tick();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_clr_vs_set overflow=%0b, required 1", overflow);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr overflow=%0b, required 0", overflow);
    end
    valve_in = 1'b0;
  endtask

  task automatic test_drain();
    do_load(8'd2);
    valve_spr = 1'b1;
    valve_drip = 1'b1;
    wait_ticks(1);
    vectors++;
    if (level !== 8'd0 || state !== 2'd2) begin
      miscompares++;
      $display("FAIL drain_sat0 level=%0d state=%0d, required 0/2", level, state);
    end
    valve_spr = 1'b0;
    valve_drip = 1'b0;
    wait_ticks(1);
    vectors++;
    if (level !== 8'd0 || state !== 2'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_steady level=%0d state=%0d ovf=%0b, required 0/0/0", level, state, overflow);
    end
  endtask

  task automatic test_faults();
    do_load(8'd120);
    step();
    fault_sel = 2'd2;
    #1;
    vectors++;
    if ({high, middle, low} !== 3'b001 || level !== 8'd120) begin
      miscompares++;
      $display("FAIL fault_mid hml=%0b%0b%0b level=%0d, required 001/120", high, middle, low, level);
    end
    fault_sel = 2'd1;
    #1;
    vectors++;
    if ({high, middle, low} !== 3'b111) begin
      miscompares++;
      $display("FAIL fault_high hml=%0b%0b%0b, required 111", high, middle, low);
    end
    fault_sel = 2'd3;
    #1;
    vectors++;
    if ({high, middle, low} !== 3'b010) begin
      miscompares++;
      $display("FAIL fault_low hml=%0b%0b%0b, required 010", high, middle, low);
    end
    fault_sel = 2'd0;
    #1;
    vectors++;
    if ({high, middle, low} !== 3'b011 || level !== 8'd120) begin
      miscompares++;
      $display("FAIL fault_none hml=%0b%0b%0b level=%0d, required 011/120", high, middle, low, level);
    end
  endtask

  task automatic test_load_on_tick();
    to_tick();
    load_level = 8'd250;
    load_valid = 1'b1;
    #1;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_tick_blocked load_ready=%0b, required 0", load_ready);
    end
    step();
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_next_cycle load_ready=%0b, required 1", load_ready);
    end
    step();
    load_valid = 1'b0;
    #1;
    vectors++;
    if (level !== 8'd200 || state !== 2'd0 || load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clamp level=%0d state=%0d rdy=%0b, required 200/0/0", level, state, load_ready);
    end
    step();
    vectors++;
    if ({high, middle, low} !== 3'b111) begin
      miscompares++;
      $display("FAIL sensors_full hml=%0b%0b%0b, required 111", high, middle, low);
    end
  endtask

  task automatic test_reset_mid_load();
    valve_in = 1'b1;
    wait_ticks(1);
    valve_in = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_before_reset overflow=%0b, required 1", overflow);
    end
    to_tick();
    load_level = 8'd50;
    load_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({level, state, overflow, load_ready, high, middle, low} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_mid_load level=%0d state=%0d ovf=%0b rdy=%0b hml=%0b%0b%0b, required all 0",
               level, state, overflow, load_ready, high, middle, low);
    end
    step();
    step();
    vectors++;
    if (load_ready !== 1'b0 || level !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold rdy=%0b level=%0d, required 0/0", load_ready, level);
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    step();
    vectors++;
    if (level !== 8'd0 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL after_release level=%0d state=%0d, required 0/0", level, state);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_full_overflow();
    test_ovf_clr();
    test_drain();
    test_faults();
    test_load_on_tick();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
